// File: rtl/aes_key_sched_seq.sv
// Word-serial AES key schedule for 128/192/256-bit keys: one w[i] per clock,
// round keys presented four words at a time on a valid/ready stream.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] xx;
        p  = 8'h00;
        xx = x;
        for (int b = 0; b < 8; b++) begin
            if (y[b]) p = p ^ xx;
            xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 via an addition chain; maps 0 to 0.
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x6   = gmul(x3, x3);
        x12  = gmul(x6, x6);
        x15  = gmul(x12, x3);
        x30  = gmul(x15, x15);
        x60  = gmul(x30, x30);
        x120 = gmul(x60, x60);
        x240 = gmul(x120, x120);
        x252 = gmul(x240, x12);
        return gmul(x252, x2);
    endfunction

    logic [7:0] b;

    always_comb begin
        b = ginv(a);
        s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
endmodule

module aes_key_sched_seq #(
    parameter int RK_IDX_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          key_len,
    input  logic [255:0]        key,
    output logic                busy,
    output logic                err,
    output logic [127:0]        rk,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [RK_IDX_W-1:0] rk_idx,
    output logic                rk_last,
    output logic                done
);
    typedef enum logic [1:0] {IDLE, GEN, OUT} state_t;

    state_t        state;
    logic [255:0]  key_r;
    logic [1:0]    len_r;
    logic [31:0]   win [8];
    logic [5:0]    wcnt;
    logic [2:0]    modc;
    logic [7:0]    rcon;

    logic [3:0]          nk;
    logic [RK_IDX_W-1:0] nr;
    logic                first;
    logic [31:0]         kw [8];
    logic [31:0]         prev_w;
    logic [31:0]         far_w;
    logic [31:0]         sb_in;
    logic [31:0]         sb_out;
    logic [31:0]         w_new;

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_kw
            assign kw[g] = key_r[255-32*g -: 32];
        end
        for (g = 0; g < 4; g++) begin : g_sbox
            aes_sbox u_sbox (.a(sb_in[8*g +: 8]), .s(sb_out[8*g +: 8]));
        end
    endgenerate

    always_comb begin
        nk     = (len_r == 2'd0) ? 4'd4 : (len_r == 2'd1) ? 4'd6 : 4'd8;
        nr     = (len_r == 2'd0) ? RK_IDX_W'(10) : (len_r == 2'd1) ? RK_IDX_W'(12) : RK_IDX_W'(14);
        first  = wcnt < {2'b00, nk};
        prev_w = win[0];
        far_w  = win[3'(nk - 4'd1)];
        sb_in  = (modc == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
        if (first)
            w_new = kw[wcnt[2:0]];
        else if (modc == 3'd0)
            w_new = far_w ^ sb_out ^ {rcon, 24'h000000};
        else if (len_r == 2'd2 && modc == 3'd4)
            w_new = far_w ^ sb_out;
        else
            w_new = far_w ^ prev_w;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            err      <= 1'b0;
            rk_valid <= 1'b0;
            rk_last  <= 1'b0;
            done     <= 1'b0;
            rk       <= '0;
            rk_idx   <= '0;
            key_r    <= '0;
            len_r    <= '0;
            wcnt     <= '0;
            modc     <= '0;
            rcon     <= 8'h01;
            for (int k = 0; k < 8; k++) win[k] <= '0;
        end else begin
            err  <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (key_len == 2'd3) begin
                            err <= 1'b1;
                        end else begin
                            key_r   <= key;
                            len_r   <= key_len;
                            wcnt    <= '0;
                            modc    <= '0;
                            rcon    <= 8'h01;
                            rk_idx  <= '0;
                            rk_last <= 1'b0;
                            busy    <= 1'b1;
                            state   <= GEN;
                        end
                    end
                end
                GEN: begin
                    win[0] <= w_new;
                    for (int k = 1; k < 8; k++) win[k] <= win[k-1];
                    case (wcnt[1:0])
                        2'd0:    rk[127:96] <= w_new;
                        2'd1:    rk[95:64]  <= w_new;
                        2'd2:    rk[63:32]  <= w_new;
                        default: rk[31:0]   <= w_new;
                    endcase
                    wcnt <= wcnt + 6'd1;
                    modc <= (modc == 3'(nk - 4'd1)) ? 3'd0 : modc + 3'd1;
                    // Rcon steps only after it has been consumed by a round-boundary word.
                    if (!first && modc == 3'd0) rcon <= xtime(rcon);
                    if (wcnt[1:0] == 2'd3) begin
                        rk_valid <= 1'b1;
                        rk_last  <= (rk_idx == nr);
                        state    <= OUT;
                    end
                end
                OUT: begin
                    if (rk_ready) begin
                        rk_valid <= 1'b0;
                        if (rk_last) begin
                            rk_last <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            rk_idx <= rk_idx + RK_IDX_W'(1);
                            state  <= GEN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_key_sched_seq.sv
// Bench for aes_key_sched_seq: known-answer vectors plus random keys and
// random backpressure, checked against a plain FIPS-197 style expansion model.

module tb_aes_key_sched_seq;
    localparam int RK_IDX_W = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [1:0]          key_len;
    logic [255:0]        key;
    logic                busy;
    logic                err;
    logic [127:0]        rk;
    logic                rk_valid;
    logic                rk_ready;
    logic [RK_IDX_W-1:0] rk_idx;
    logic                rk_last;
    logic                done;

    aes_key_sched_seq #(.RK_IDX_W(RK_IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key(key),
        .busy(busy), .err(err), .rk(rk), .rk_valid(rk_valid), .rk_ready(rk_ready),
        .rk_idx(rk_idx), .rk_last(rk_last), .done(done)
    );

    always #5 clk = ~clk;

    int           errors = 0;
    int           checks = 0;
    logic [7:0]   sbox [256];
    logic [31:0]  wm [60];
    logic [127:0] got [15];
    logic [127:0] ref128 [11];

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // S-box generated by walking the multiplicative group with generator 3.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int n = 0; n < 255; n++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox[p] = x ^ 8'h63;
        end
        sbox[0] = 8'h63;
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
    endfunction

    task automatic build_model(input int nk, input logic [255:0] k);
        logic [7:0]  rc [10];
        logic [31:0] t;
        rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        for (int i = 0; i < nk; i++) wm[i] = k[255-32*i -: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = wm[i-1];
            if (i % nk == 0)
                t = subw({t[23:0], t[31:24]}) ^ {rc[i/nk-1], 24'h0};
            else if (nk == 8 && i % nk == 4)
                t = subw(t);
            wm[i] = wm[i-nk] ^ t;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_err"}, 128'(err), 128'(0));
        chk({tag, "_valid"}, 128'(rk_valid), 128'(0));
        chk({tag, "_last"}, 128'(rk_last), 128'(0));
        chk({tag, "_done"}, 128'(done), 128'(0));
        chk({tag, "_rk"}, rk, 128'(0));
        chk({tag, "_idx"}, 128'(rk_idx), 128'(0));
    endtask

    task automatic run(input logic [1:0] kl, input logic [255:0] k, input int stall_idx,
                       input int stall_n, input int abort_idx, input bit mid_start,
                       output int hs);
        int nk, nr, cyc, prev, guard, stall_eff;
        logic [127:0]        held;
        logic [RK_IDX_W-1:0] held_idx;
        bit                  seen;
        nk = (kl == 2'd0) ? 4 : (kl == 2'd1) ? 6 : 8;
        nr = nk + 6;
        stall_eff = (stall_idx <= nr) ? stall_n : 0;
        build_model(nk, k);
        hs = 0; cyc = 0; prev = 0;
        key = k; key_len = kl; start = 1'b1; rk_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        key = ~k;
        key_len = 2'($urandom_range(0, 3));
        chk("busy_after_start", 128'(busy), 128'(1));
        for (int j = 0; j <= nr; j++) begin
            guard = 0;
            while (rk_valid !== 1'b1 && guard < 12) begin
                start = mid_start && (j == 2) && (guard < 2);
                @(posedge clk); #1;
                cyc++; guard++;
                if (mid_start && j == 2) chk("no_err_while_busy", 128'(err), 128'(0));
            end
            start = 1'b0;
            chk($sformatf("valid_seen_%0d", j), 128'(rk_valid), 128'(1));
            chk($sformatf("latency_%0d", j), 128'(cyc - prev), 128'(4));
            chk($sformatf("rk_%0d", j), rk, {wm[4*j], wm[4*j+1], wm[4*j+2], wm[4*j+3]});
            chk($sformatf("rk_idx_%0d", j), 128'(rk_idx), 128'(j));
            chk($sformatf("rk_last_%0d", j), 128'(rk_last), 128'(j == nr));
            got[j] = rk;
            if (j == abort_idx) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                check_all_zero("abort");
                seen = 1'b0;
                repeat (6) begin
                    @(posedge clk); #1;
                    if (rk_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
                end
                chk("quiet_after_abort", 128'(seen), 128'(0));
                return;
            end
            if (j == stall_idx) begin
                rk_ready = 1'b0;
                held = rk;
                held_idx = rk_idx;
                for (int n = 0; n < stall_n; n++) begin
                    @(posedge clk); #1;
                    cyc++;
                    chk("stall_valid", 128'(rk_valid), 128'(1));
                    chk("stall_rk", rk, held);
                    chk("stall_idx", 128'(rk_idx), 128'(held_idx));
                end
                rk_ready = 1'b1;
            end
            @(posedge clk); #1;
            cyc++; hs++; prev = cyc;
            chk("valid_drop", 128'(rk_valid), 128'(0));
            if (j == nr) begin
                chk("done_pulse", 128'(done), 128'(1));
                chk("busy_end", 128'(busy), 128'(0));
                chk("run_cycles", 128'(cyc), 128'(5 * (nr + 1) + stall_eff));
                @(posedge clk); #1;
                chk("done_single", 128'(done), 128'(0));
            end else begin
                chk("done_early", 128'(done), 128'(0));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, kl, nr, sidx, sn;
        logic [255:0] rkey;

        build_sbox();
        rst_n = 1'b0; start = 1'b1; key_len = 2'd0; key = '1; rk_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        key_len = 2'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("illegal_err", 128'(err), 128'(1));
        chk("illegal_busy", 128'(busy), 128'(0));
        @(posedge clk); #1;
        chk("illegal_err_single", 128'(err), 128'(0));
        chk("illegal_stays_idle", 128'(busy), 128'(0));

        run(2'd0, K128, 99, 0, 99, 1'b1, hs);
        chk("kat128_rk1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("kat128_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("kat128_hs", 128'(hs), 128'(11));
        for (int j = 0; j < 11; j++) ref128[j] = got[j];

        run(2'd1, K192, 99, 0, 99, 1'b0, hs);
        chk("kat192_rk1", got[1], 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
        chk("kat192_rk12_w3", 128'(got[12][31:0]), 128'h01002202);
        chk("kat192_hs", 128'(hs), 128'(13));

        run(2'd2, K256, 99, 0, 99, 1'b0, hs);
        chk("kat256_rk2", got[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
        chk("kat256_rk14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);
        chk("kat256_hs", 128'(hs), 128'(15));

        run(2'd0, K128, 3, 7, 99, 1'b0, hs);
        for (int j = 0; j < 11; j++) chk($sformatf("bp_rk_%0d", j), got[j], ref128[j]);

        run(2'd0, K128, 99, 0, 5, 1'b0, hs);
        run(2'd0, K128, 99, 0, 99, 1'b0, hs);
        for (int j = 0; j < 11; j++) chk($sformatf("rerun_rk_%0d", j), got[j], ref128[j]);

        for (int r = 0; r < 6; r++) begin
            for (int w = 0; w < 8; w++) rkey[255-32*w -: 32] = $urandom();
            kl = $urandom_range(0, 2);
            nr = (kl == 0) ? 10 : (kl == 1) ? 12 : 14;
            sidx = $urandom_range(0, nr + 2);
            sn = $urandom_range(1, 6);
            run(2'(kl), rkey, sidx, sn, 99, r[0], hs);
            chk("rand_hs", 128'(hs), 128'(nr + 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
